vga_timing_gen: RTL and testbench

Generates the raster timing that the game top consumes. It has a free-running column/row counter pair and emits the counter-style i_HSync/i_VSync signals that feed frogger_game. It also drives the physical VGA connector: it takes the game's RGB back, realigns the syncs to that RGB with a configurable delay, inserts front porch, sync pulse and back porch, and blanks colour outside the active area. It is the source end of the sync interface the game receives, and the sink end of the game's video output.

---
 rtl/vga_timing_pkg.sv | 29 ++
 rtl/vga_timing_gen_sync_delay_line.sv | 33 +++
 rtl/vga_timing_gen.sv | 136 +++++++++++++
 tb/tb_vga_timing_gen.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and the col/row pair
// carried by the sync delay line.
package vga_timing_pkg;

  localparam int unsigned TOTAL_COLS    = 800;
  localparam int unsigned TOTAL_ROWS    = 525;
  localparam int unsigned ACTIVE_COLS   = 640;
  localparam int unsigned ACTIVE_ROWS   = 480;
  localparam int unsigned H_FRONT_PORCH = 16;
  localparam int unsigned H_SYNC_WIDTH  = 96;
  localparam int unsigned V_FRONT_PORCH = 10;
  localparam int unsigned V_SYNC_WIDTH  = 2;
  localparam int unsigned VIDEO_DELAY   = 2;

  localparam int unsigned H_SYNC_START =
    ACTIVE_COLS + H_FRONT_PORCH;
  localparam int unsigned H_SYNC_END =
    H_SYNC_START + H_SYNC_WIDTH - 1;
  localparam int unsigned V_SYNC_START =
    ACTIVE_ROWS + V_FRONT_PORCH;
  localparam int unsigned V_SYNC_END =
    V_SYNC_START + V_SYNC_WIDTH - 1;

  typedef struct packed {
    logic [9:0] col;
    logic [9:0] row;
  } pos_t;

endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Shift register of DEPTH stages, reset to INIT.
// Ports: clk_i, rst_ni (sync, active-low), d_i -> q_o.
module sync_delay_line #(
  parameter int unsigned   DEPTH = 2,
  parameter int unsigned   W     = 20,
  parameter logic [W-1:0]  INIT  = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  if (DEPTH == 0) begin : g_pass
    logic unused;
    assign unused = clk_i ^ rst_ni;
    assign q_o = d_i;
  end else begin : g_sr
    logic [W-1:0] sr_q [DEPTH];
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        for (int i = 0; i < DEPTH; i++)
          sr_q[i] <= INIT;
      end else begin
        sr_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++)
          sr_q[i] <= sr_q[i-1];
      end
    end
    assign q_o = sr_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counter for the game plus the VGA connector stage.
// Ports: i_Clk, i_Rst_L; o_HSync/o_VSync/o_Col/Row_Count/
// o_Frame_Start to the game; i_*_Video back; o_VGA_* out.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned c_TOTAL_COLS    = TOTAL_COLS,
  parameter int unsigned c_TOTAL_ROWS    = TOTAL_ROWS,
  parameter int unsigned c_ACTIVE_COLS   = ACTIVE_COLS,
  parameter int unsigned c_ACTIVE_ROWS   = ACTIVE_ROWS,
  parameter int unsigned c_H_FRONT_PORCH = H_FRONT_PORCH,
  parameter int unsigned c_H_SYNC_WIDTH  = H_SYNC_WIDTH,
  parameter int unsigned c_V_FRONT_PORCH = V_FRONT_PORCH,
  parameter int unsigned c_V_SYNC_WIDTH  = V_SYNC_WIDTH,
  parameter int unsigned c_VIDEO_DELAY   = VIDEO_DELAY
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  output logic       o_HSync,
  output logic       o_VSync,
  output logic [9:0] o_Col_Count,
  output logic [9:0] o_Row_Count,
  output logic       o_Frame_Start,
  input  logic [3:0] i_Red_Video,
  input  logic [3:0] i_Grn_Video,
  input  logic [3:0] i_Blu_Video,
  output logic       o_VGA_HSync,
  output logic       o_VGA_VSync,
  output logic [3:0] o_VGA_Red,
  output logic [3:0] o_VGA_Grn,
  output logic [3:0] o_VGA_Blu
);

  if (c_ACTIVE_COLS + c_H_FRONT_PORCH + c_H_SYNC_WIDTH
      > c_TOTAL_COLS) begin : g_bad_h
    $error("horizontal timing exceeds c_TOTAL_COLS");
  end
  if (c_ACTIVE_ROWS + c_V_FRONT_PORCH + c_V_SYNC_WIDTH
      > c_TOTAL_ROWS) begin : g_bad_v
    $error("vertical timing exceeds c_TOTAL_ROWS");
  end
  if (c_VIDEO_DELAY > 7) begin : g_bad_d
    $error("c_VIDEO_DELAY must be 0..7");
  end

  localparam logic [9:0] LP_COL_MAX = 10'(c_TOTAL_COLS - 1);
  localparam logic [9:0] LP_ROW_MAX = 10'(c_TOTAL_ROWS - 1);
  localparam logic [9:0] LP_ACT_C   = 10'(c_ACTIVE_COLS);
  localparam logic [9:0] LP_ACT_R   = 10'(c_ACTIVE_ROWS);
  localparam logic [9:0] LP_HS_BEG  =
    10'(c_ACTIVE_COLS + c_H_FRONT_PORCH);
  localparam logic [9:0] LP_HS_END  =
    10'(c_ACTIVE_COLS + c_H_FRONT_PORCH + c_H_SYNC_WIDTH - 1);
  localparam logic [9:0] LP_VS_BEG  =
    10'(c_ACTIVE_ROWS + c_V_FRONT_PORCH);
  localparam logic [9:0] LP_VS_END  =
    10'(c_ACTIVE_ROWS + c_V_FRONT_PORCH + c_V_SYNC_WIDTH - 1);
  localparam pos_t LP_RST_POS =
    '{col: LP_COL_MAX, row: LP_ROW_MAX};

  logic [9:0] col_q, col_d;
  logic [9:0] row_q, row_d;
  logic       hs_q, vs_q, fs_q;

  always_comb begin
    col_d = col_q + 10'd1;
    row_d = row_q;
    if (col_q == LP_COL_MAX) begin
      col_d = '0;
      row_d = (row_q == LP_ROW_MAX) ? '0 : row_q + 10'd1;
    end
  end

  // Game syncs come from the next-state counts so they line
  // up with the counts shown in the same cycle.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      col_q <= LP_COL_MAX;
      row_q <= LP_ROW_MAX;
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      hs_q  <= col_d < LP_ACT_C;
      vs_q  <= row_d < LP_ACT_R;
      fs_q  <= (col_d == '0) && (row_d == '0);
    end
  end

  pos_t cur, dly;
  assign cur = '{col: col_q, row: row_q};

  sync_delay_line #(
    .DEPTH (c_VIDEO_DELAY),
    .W     ($bits(pos_t)),
    .INIT  (LP_RST_POS)
  ) u_dly (
    .clk_i  (i_Clk),
    .rst_ni (i_Rst_L),
    .d_i    (cur),
    .q_o    (dly)
  );

  logic        active;
  logic        vhs_q, vvs_q;
  logic [11:0] rgb_q;

  assign active = (dly.col < LP_ACT_C) && (dly.row < LP_ACT_R);

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      vhs_q <= 1'b1;
      vvs_q <= 1'b1;
      rgb_q <= '0;
    end else begin
      vhs_q <= !((dly.col >= LP_HS_BEG) && (dly.col <= LP_HS_END));
      vvs_q <= !((dly.row >= LP_VS_BEG) && (dly.row <= LP_VS_END));
      rgb_q <= active ? {i_Red_Video, i_Grn_Video, i_Blu_Video}
                      : 12'h000;
    end
  end

  assign o_HSync       = hs_q;
  assign o_VSync       = vs_q;
  assign o_Col_Count   = col_q;
  assign o_Row_Count   = row_q;
  assign o_Frame_Start = fs_q;
  assign o_VGA_HSync   = vhs_q;
  assign o_VGA_VSync   = vvs_q;
  assign o_VGA_Red     = rgb_q[11:8];
  assign o_VGA_Grn     = rgb_q[7:4];
  assign o_VGA_Blu     = rgb_q[3:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: default-timing DUT (delay 2) and a short
// frame DUT (16 rows, delay 0) driven from one clock/reset.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  localparam int DA = 2;
  localparam int DB = 0;
  localparam int TRB = 16;
  localparam int ARB = 8;
  localparam int VSB0 = 10;
  localparam int VSB1 = 11;

  typedef struct {
    int         col;
    int         row;
    logic [11:0] rgb;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [11:0] rgb;

  logic a_hs, a_vs, a_fs, a_vhs, a_vvs;
  logic [9:0] a_col, a_row;
  logic [3:0] a_r, a_g, a_b;
  logic b_hs, b_vs, b_fs, b_vhs, b_vvs;
  logic [9:0] b_col, b_row;
  logic [3:0] b_r, b_g, b_b;

  always #5 clk = ~clk;

  vga_timing_gen #(.c_VIDEO_DELAY(DA)) u_a (
    .i_Clk(clk), .i_Rst_L(rst_n),
    .o_HSync(a_hs), .o_VSync(a_vs),
    .o_Col_Count(a_col), .o_Row_Count(a_row),
    .o_Frame_Start(a_fs),
    .i_Red_Video(rgb[11:8]), .i_Grn_Video(rgb[7:4]),
    .i_Blu_Video(rgb[3:0]),
    .o_VGA_HSync(a_vhs), .o_VGA_VSync(a_vvs),
    .o_VGA_Red(a_r), .o_VGA_Grn(a_g), .o_VGA_Blu(a_b)
  );

  vga_timing_gen #(
    .c_TOTAL_ROWS(TRB), .c_ACTIVE_ROWS(ARB),
    .c_V_FRONT_PORCH(2), .c_V_SYNC_WIDTH(2),
    .c_VIDEO_DELAY(DB)
  ) u_b (
    .i_Clk(clk), .i_Rst_L(rst_n),
    .o_HSync(b_hs), .o_VSync(b_vs),
    .o_Col_Count(b_col), .o_Row_Count(b_row),
    .o_Frame_Start(b_fs),
    .i_Red_Video(rgb[11:8]), .i_Grn_Video(rgb[7:4]),
    .i_Blu_Video(rgb[3:0]),
    .o_VGA_HSync(b_vhs), .o_VGA_VSync(b_vvs),
    .o_VGA_Red(b_r), .o_VGA_Grn(b_g), .o_VGA_Blu(b_b)
  );

  int n_assert = 0;
  int n_fail = 0;
  int mcol, mra, mrb;
  ent_t qa[$], qb[$];
  bit fff = 0;
  logic pa_vhs = 1, pb_vhs = 1, pb_vvs = 1;
  int run_a = 0, run_b = 0, run_v = 0;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] vexp(
    ent_t e, int ar, int vs0, int vs1);
    logic act, hs, vs;
    act = e.col < ACTIVE_COLS && e.row < ar;
    hs  = !(e.col >= H_SYNC_START && e.col <= H_SYNC_END);
    vs  = !(e.row >= vs0 && e.row <= vs1);
    return {hs, vs, act ? e.rgb : 12'h000};
  endfunction

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
  endtask

  task automatic tick();
    ent_t e, ea, eb;
    logic [13:0] x;
    @(posedge clk);
    if (!rst_n) begin
      mcol = TOTAL_COLS - 1;
      mra  = TOTAL_ROWS - 1;
      mrb  = TRB - 1;
      e = '{mcol, mra, 12'h000};
      qa.delete();
      repeat (DA + 1) qa.push_back(e);
      e.row = mrb;
      qb.delete();
      repeat (DB + 1) qb.push_back(e);
    end else if (mcol == TOTAL_COLS - 1) begin
      mcol = 0;
      mra = (mra == TOTAL_ROWS - 1) ? 0 : mra + 1;
      mrb = (mrb == TRB - 1) ? 0 : mrb + 1;
    end else begin
      mcol++;
    end
    @(negedge clk);
    chk("a_col", a_col, mcol);
    chk("a_row", a_row, mra);
    chk("a_hsync", a_hs, mcol < ACTIVE_COLS);
    chk("a_vsync", a_vs, mra < ACTIVE_ROWS);
    chk("a_frame", a_fs, mcol == 0 && mra == 0);
    chk("b_row", b_row, mrb);
    chk("b_col", b_col, mcol);
    chk("b_vsync", b_vs, mrb < ARB);
    chk("b_frame", b_fs, mcol == 0 && mrb == 0);
    qa.push_back('{mcol, mra, 12'h000});
    ea = qa.pop_front();
    x = vexp(ea, ACTIVE_ROWS, V_SYNC_START, V_SYNC_END);
    chk("a_vga_hs", a_vhs, x[13]);
    chk("a_vga_vs", a_vvs, x[12]);
    chk("a_vga_rgb", {a_r, a_g, a_b}, x[11:0]);
    qb.push_back('{mcol, mrb, 12'h000});
    eb = qb.pop_front();
    x = vexp(eb, ARB, VSB0, VSB1);
    chk("b_vga_hs", b_vhs, x[13]);
    chk("b_vga_vs", b_vvs, x[12]);
    chk("b_vga_rgb", {b_r, b_g, b_b}, x[11:0]);
    // Pulse edges and widths measured straight off the pins.
    if (pa_vhs && !a_vhs)
      chk("a_vhs_fall_col", mcol, H_SYNC_START + DA + 1);
    if (!pa_vhs && a_vhs) begin
      chk("a_vhs_width", run_a, H_SYNC_WIDTH);
      run_a = 0;
    end
    if (!a_vhs) run_a++;
    if (pb_vhs && !b_vhs)
      chk("b_vhs_fall_col", mcol, H_SYNC_START + DB + 1);
    if (!pb_vhs && b_vhs) begin
      chk("b_vhs_width", run_b, H_SYNC_WIDTH);
      run_b = 0;
    end
    if (!b_vhs) run_b++;
    if (pb_vvs && !b_vvs) begin
      chk("b_vvs_fall_col", mcol, DB + 1);
      chk("b_vvs_fall_row", mrb, VSB0);
    end
    if (!pb_vvs && b_vvs) begin
      chk("b_vvs_width", run_v, 2 * TOTAL_COLS);
      run_v = 0;
    end
    if (!b_vvs) run_v++;
    pa_vhs = a_vhs;
    pb_vhs = b_vhs;
    pb_vvs = b_vvs;
    rgb = fff ? 12'hFFF : 12'($urandom);
    qa[0].rgb = rgb;
    qb[0].rgb = rgb;
    if (n_fail > 100) begin
      summary();
      $finish;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rgb = 12'h000;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("first_col", a_col, 0);
    chk("first_fs", a_fs, 1);
    repeat (3 * TOTAL_COLS) tick();
    for (int i = 0; i < 20000; i++) begin
      if (mcol == 300 && mra == 20) break;
      tick();
    end
    chk("mid_col", a_col, 300);
    chk("mid_row", a_row, 20);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_col", a_col, TOTAL_COLS - 1);
    chk("mid_rst_vhs", a_vhs, 1);
    rst_n = 1'b1;
    repeat (10) tick();
    fff = 1;
    repeat (26000) tick();
    summary();
    $finish;
  end

endmodule
